// File: rtl/alu_axi_burst_slave.sv
// rtl/alu_axi_burst_slave.sv - AXI4 INCR burst register front-end for a combinational ALU
module alu_axi_burst_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [DATA_WIDTH-1:0] alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    // init_q holds the address channels closed until the first edge after reset release
    logic                  init_q;
    w_state_t              w_state_q, w_state_d;
    logic [1:0]            w_idx_q, w_idx_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic                  w_err_q, w_err_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, opc_q, opc_d;
    r_state_t              r_state_q, r_state_d;
    logic [1:0]            r_idx_q, r_idx_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0] word [4];
    logic [1:0]            rd_sel;
    logic [31:0]           rd_word;
    logic                  unused_bits;

    assign word[0] = op1_q;
    assign word[1] = op2_q;
    assign word[2] = opc_q;
    assign word[3] = alu_result;

    // Only addr[3:2], wdata[DATA_WIDTH-1:0] and wstrb[0] carry meaning here
    assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_wstrb};

    // Write burst FSM: address latch, per-beat register load and error tracking, response
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        opc_d     = opc_q;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && init_q) begin
                    w_idx_d   = s_axi_awaddr[3:2];
                    w_cnt_d   = s_axi_awlen;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    if (w_idx_q == 2'd3) begin
                        w_err_d = 1'b1;
                    end else if (s_axi_wstrb[0]) begin
                        case (w_idx_q)
                            2'd0:    op1_d = s_axi_wdata[DATA_WIDTH-1:0];
                            2'd1:    op2_d = s_axi_wdata[DATA_WIDTH-1:0];
                            default: opc_d = s_axi_wdata[DATA_WIDTH-1:0];
                        endcase
                    end
                    if (s_axi_wlast != (w_cnt_q == 8'd0)) begin
                        w_err_d = 1'b1;
                    end
                    w_idx_d = w_idx_q + 2'd1;
                    w_cnt_d = w_cnt_q - 8'd1;
                    // The beat count, not wlast, terminates the burst
                    if (w_cnt_q == 8'd0) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read word selection: first beat comes from araddr, later beats from the advanced index
    always_comb begin
        rd_sel                    = (r_state_q == R_IDLE) ? s_axi_araddr[3:2] : r_idx_q + 2'd1;
        rd_word                   = '0;
        rd_word[DATA_WIDTH-1:0]   = word[rd_sel];
    end

    // Read burst FSM: rdata is registered so a stalled beat stays stable
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && init_q) begin
                    r_idx_d   = s_axi_araddr[3:2];
                    r_cnt_d   = s_axi_arlen;
                    rdata_d   = rd_word;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (r_cnt_q == 8'd0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_idx_q + 2'd1;
                        r_cnt_d = r_cnt_q - 8'd1;
                        rdata_d = rd_word;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State and register update; reset aborts any burst in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q    <= 1'b0;
            w_state_q <= W_IDLE;
            w_idx_q   <= 2'd0;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            opc_q     <= '0;
            r_state_q <= R_IDLE;
            r_idx_q   <= 2'd0;
            r_cnt_q   <= 8'd0;
            rdata_q   <= 32'd0;
        end else begin
            init_q    <= 1'b1;
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            opc_q     <= opc_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axi_awready = init_q && (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bresp   = (s_axi_bvalid && w_err_q) ? 2'b10 : 2'b00;
    assign s_axi_arready = init_q && (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rlast   = (r_state_q == R_DATA) && (r_cnt_q == 8'd0);
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rdata   = rdata_q;
    assign alu_op1       = op1_q;
    assign alu_op2       = op2_q;
    assign alu_opcode    = opc_q;

endmodule

// File: tb/tb_alu_axi_burst_slave.sv
// tb/tb_alu_axi_burst_slave.sv - randomized, model-checked bench for alu_axi_burst_slave
module tb_alu_axi_burst_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic        awvalid = 1'b0, awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready = 1'b0;
    logic        arvalid = 1'b0, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready = 1'b0;
    logic [7:0]  alu_op1, alu_op2, alu_opcode, alu_result;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [7:0]  m_reg [3];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];
    logic [7:0]  r_q [$];
    logic [1:0]  b_q [$];
    bit          prev_rv, prev_rr, prev_bv, prev_br;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        case (op)
            8'd0:    return a + b;
            8'd1:    return a - b;
            8'd2:    return ~a;
            8'd3:    return a & b;
            8'd4:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op1, alu_op2, alu_opcode);

    alu_axi_burst_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode), .alu_result(alu_result)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input int idx);
        return (idx < 3) ? m_reg[idx] : alu_f(m_reg[0], m_reg[1], m_reg[2]);
    endfunction

    function automatic logic [1:0] calc_bresp(input logic [3:0] addr, input int len);
        bit err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ((int'(addr[3:2]) + i) % 4 == 3) err = 1'b1;
            if (wl[i] != (i == len)) err = 1'b1;
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    // Per-cycle comparison of DUT outputs against the model and the expected-beat queues
    always @(negedge clk) begin
        if (rst || !chk_en) begin
            prev_rv = 1'b0; prev_rr = 1'b0; prev_bv = 1'b0; prev_br = 1'b0;
        end else begin
            chk("alu_op1", {24'd0, alu_op1}, {24'd0, m_reg[0]});
            chk("alu_op2", {24'd0, alu_op2}, {24'd0, m_reg[1]});
            chk("alu_opcode", {24'd0, alu_opcode}, {24'd0, m_reg[2]});
            if (prev_rv && !prev_rr) chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
            if (prev_bv && !prev_br) chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
            if (rvalid) begin
                if (r_q.size() == 0) chk("rvalid_unexpected", {31'd0, rvalid}, 32'd0);
                else begin
                    chk("rdata", rdata, {24'd0, r_q[0]});
                    chk("rlast", {31'd0, rlast}, {31'd0, r_q.size() == 1});
                    chk("rresp", {30'd0, rresp}, 32'd0);
                    if (rready) void'(r_q.pop_front());
                end
            end
            if (bvalid) begin
                if (b_q.size() == 0) chk("bvalid_unexpected", {31'd0, bvalid}, 32'd0);
                else begin
                    chk("bresp", {30'd0, bresp}, {30'd0, b_q[0]});
                    if (bready) void'(b_q.pop_front());
                end
            end
            prev_rv = rvalid; prev_rr = rready; prev_bv = bvalid; prev_br = bready;
        end
    end

    task automatic reset_abort();
        rst = 1'b1;
        #1;
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ops", {8'd0, alu_op1, alu_op2, alu_opcode}, 32'd0);
        for (int k = 0; k < 3; k++) m_reg[k] = 8'd0;
        r_q.delete();
        b_q.delete();
        wvalid = 1'b0; awvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] addr, input int len, input int bdelay, input int abort_beat);
        int k;
        b_q.push_back(calc_bresp(addr, len));
        @(posedge clk); #1;
        awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!awready && k < 100);
        chk("aw_handshake", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk); #1;
            end
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = wl[i];
            if (i == abort_beat) begin
                #2;
                reset_abort();
                return;
            end
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!wready && k < 100);
            chk("w_handshake", {31'd0, wready}, 32'd1);
            @(posedge clk); #1;
            if (((int'(addr[3:2]) + i) % 4) < 3 && ws[i][0])
                m_reg[(int'(addr[3:2]) + i) % 4] = wd[i][7:0];
            wvalid = 1'b0;
        end
        repeat (bdelay) begin
            @(posedge clk); #1;
        end
        bready = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bvalid && k < 100);
        chk("b_handshake", {31'd0, bvalid}, 32'd1);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] addr, input int len, input int mode);
        int k;
        int got;
        for (int i = 0; i <= len; i++) r_q.push_back(m_read((int'(addr[3:2]) + i) % 4));
        @(posedge clk); #1;
        araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!arready && k < 100);
        chk("ar_handshake", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        got = 0;
        k = 0;
        while (got <= len && k < 300) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (k % 3 == 0);
                default: rready = 1'($urandom_range(1));
            endcase
            @(negedge clk);
            if (rvalid && rready) got++;
            @(posedge clk); #1;
            k++;
        end
        chk("r_beats", got, len + 1);
        rready = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) m_reg[k] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_awready", {31'd0, awready}, 32'd0);
        chk("reset_arready", {31'd0, arready}, 32'd0);
        chk("reset_valids", {29'd0, rvalid, bvalid, rlast}, 32'd0);
        chk("reset_wready", {31'd0, wready}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_ops", {8'd0, alu_op1, alu_op2, alu_opcode}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("awready_before_edge", {31'd0, awready}, 32'd0);
        @(posedge clk); #1;
        chk("awready_after_edge", {31'd0, awready}, 32'd1);
        chk("arready_after_edge", {31'd0, arready}, 32'd1);
        chk_en = 1'b1;

        wd[0] = 32'd5; wd[1] = 32'd3; wd[2] = 32'd0;
        ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        wl[0] = 1'b0; wl[1] = 1'b0; wl[2] = 1'b1;
        chk("pin_bresp_okay", {30'd0, calc_bresp(4'h0, 2)}, 32'd0);
        do_write(4'h0, 2, 0, -1);
        chk("pin_result_8", {24'd0, m_read(3)}, 32'd8);
        do_read(4'hC, 0, 0);
        do_read(4'h0, 3, 0);

        wd[0] = 32'd2; wd[1] = 32'hAA; wd[2] = 32'h11;
        chk("pin_bresp_slverr", {30'd0, calc_bresp(4'h8, 2)}, 32'd2);
        do_write(4'h8, 2, 0, -1);
        chk("pin_opcode_2", {24'd0, m_reg[2]}, 32'd2);
        chk("pin_op1_11", {24'd0, m_reg[0]}, 32'h11);
        chk("pin_result_ee", {24'd0, m_read(3)}, 32'hEE);
        do_read(4'hC, 0, 0);

        wd[0] = 32'h77; ws[0] = 4'h0; wl[0] = 1'b1;
        do_write(4'h0, 0, 0, -1);
        chk("pin_strb0_keep", {24'd0, m_reg[0]}, 32'h11);
        wd[0] = 32'd9; wd[1] = 32'd4; wd[2] = 32'd1;
        ws[0] = 4'hF; wl[0] = 1'b0; wl[1] = 1'b1; wl[2] = 1'b0;
        chk("pin_early_wlast", {30'd0, calc_bresp(4'h0, 2)}, 32'd2);
        do_write(4'h0, 2, 0, -1);

        do_read(4'h0, 3, 1);
        wd[0] = 32'h21; wl[0] = 1'b1;
        do_write(4'h4, 0, 5, -1);
        do_read(4'h4, 5, 1);

        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'h30 + i; ws[i] = 4'hF; wl[i] = (i == 3);
        end
        do_write(4'h0, 3, 0, 2);
        chk("abort_regs", {8'd0, m_reg[0], m_reg[1], m_reg[2]}, 32'd0);
        wd[0] = 32'd7; wd[1] = 32'd6; wd[2] = 32'd1;
        wl[0] = 1'b0; wl[1] = 1'b0; wl[2] = 1'b1;
        do_write(4'h0, 2, 1, -1);
        do_read(4'h0, 3, 0);

        for (int it = 0; it < 30; it++) begin
            int len = $urandom_range(5);
            logic [3:0] a = 4'($urandom);
            for (int i = 0; i <= len; i++) begin
                wd[i] = $urandom;
                ws[i] = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom) | 4'h1;
                wl[i] = (i == len) ^ ($urandom_range(7) == 0);
            end
            do_write(a, len, $urandom_range(3), -1);
            do_read(4'($urandom), $urandom_range(6), $urandom_range(2));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("r_queue_empty", r_q.size(), 0);
        chk("b_queue_empty", b_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
